// File: rtl/interboard_link.sv
// Board-to-board message link: serialises MSG_BITS messages into DATA_W chunks over a
// 4-phase Request/Ack cable, deserialises the reverse direction, and signals link reset.
module interboard_link #(
    parameter int DATA_W   = 6,
    parameter int MSG_BITS = 22,
    parameter int RST_HOLD = 10,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                transmit,
    input  logic                tx_valid,
    input  logic [MSG_BITS-1:0] tx_data,
    output logic                tx_ready,
    output logic                tx_err,
    input  logic                link_rst_req,
    input  logic                Request_in,
    input  logic                Ack_in,
    input  logic [DATA_W-1:0]   inter_data_in,
    output logic                Request_out,
    output logic                Ack_out,
    output logic [DATA_W-1:0]   inter_data_out,
    output logic                rx_valid,
    output logic [MSG_BITS-1:0] rx_data,
    output logic                remote_rst,
    output logic [1:0]          o_dbg_tx_state,
    output logic                o_dbg_rx_state
);
    localparam int NCHUNK = (MSG_BITS + DATA_W - 1) / DATA_W;
    localparam int PAD_W  = NCHUNK * DATA_W;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HW     = $clog2(RST_HOLD + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} tx_state_t;
    typedef enum logic {R_WAIT, R_HOLD} rx_state_t;

    // Message handshake: a message is taken on a cycle where tx_valid=1 and tx_ready=1
    // (with transmit=1); tx_valid on any other cycle is dropped, never queued.

    logic              r_req_s1, r_req_s2, r_ack_s1, r_ack_s2;
    logic [DATA_W-1:0] r_din_s1, r_din_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
            r_din_s1 <= '0;
            r_din_s2 <= '0;
        end else begin
            r_req_s1 <= Request_in;
            r_req_s2 <= r_req_s1;
            r_ack_s1 <= Ack_in;
            r_ack_s2 <= r_ack_s1;
            r_din_s1 <= inter_data_in;
            r_din_s2 <= r_din_s1;
        end
    end

    logic [HW-1:0] r_hold_cnt;
    logic          w_hold, w_hold_nxt;
    logic          r_all1_q, r_pat2_q, r_remote_rst;
    logic          w_all1, w_pat2, w_abort;

    assign w_hold     = (r_hold_cnt != '0);
    assign w_hold_nxt = link_rst_req | (r_hold_cnt > HW'(1));
    assign w_all1     = &{r_ack_s2, r_req_s2, r_din_s2};
    assign w_pat2     = w_all1 & r_all1_q;
    assign w_abort    = link_rst_req | w_hold | w_pat2;

    // r_pat2_q follows the raw pattern so a long pattern yields a single pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt   <= '0;
            r_all1_q     <= 1'b0;
            r_pat2_q     <= 1'b0;
            r_remote_rst <= 1'b0;
        end else begin
            if (link_rst_req)
                r_hold_cnt <= HW'(RST_HOLD);
            else if (w_hold)
                r_hold_cnt <= r_hold_cnt - 1'b1;
            r_all1_q     <= w_all1;
            r_pat2_q     <= w_pat2;
            r_remote_rst <= w_pat2 & ~r_pat2_q & ~w_hold;
        end
    end

    tx_state_t         r_tx_st;
    logic [KW-1:0]     r_tx_k;
    logic [TW-1:0]     r_tx_tmr;
    logic [PAD_W-1:0]  r_tx_sh;
    logic [PAD_W-1:0]  w_tx_pad, w_tx_next;
    logic              r_req_out, r_tx_ready, r_tx_err;
    logic [DATA_W-1:0] r_dout;
    logic              w_tmo;

    assign w_tx_pad  = PAD_W'(tx_data);
    assign w_tx_next = r_tx_sh >> DATA_W;
    assign w_tmo     = (r_tx_tmr == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_st    <= S_IDLE;
            r_tx_k     <= '0;
            r_tx_tmr   <= '0;
            r_tx_sh    <= '0;
            r_req_out  <= 1'b0;
            r_dout     <= '0;
            r_tx_ready <= 1'b0;
            r_tx_err   <= 1'b0;
        end else begin
            r_tx_err <= 1'b0;
            if (w_abort || !transmit) begin
                r_tx_st    <= S_IDLE;
                r_tx_k     <= '0;
                r_tx_tmr   <= '0;
                r_req_out  <= 1'b0;
                r_dout     <= '0;
                r_tx_ready <= ~w_hold_nxt;
            end else begin
                case (r_tx_st)
                    S_IDLE: begin
                        r_tx_ready <= 1'b1;
                        if (tx_valid && r_tx_ready) begin
                            r_tx_sh    <= w_tx_pad;
                            r_dout     <= w_tx_pad[DATA_W-1:0];
                            r_req_out  <= 1'b1;
                            r_tx_k     <= '0;
                            r_tx_tmr   <= '0;
                            r_tx_ready <= 1'b0;
                            r_tx_st    <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (r_ack_s2) begin
                            r_req_out <= 1'b0;
                            r_tx_tmr  <= '0;
                            r_tx_st   <= S_REL;
                        end else if (w_tmo) begin
                            r_tx_err   <= 1'b1;
                            r_req_out  <= 1'b0;
                            r_dout     <= '0;
                            r_tx_ready <= 1'b1;
                            r_tx_st    <= S_IDLE;
                        end else begin
                            r_tx_tmr <= r_tx_tmr + 1'b1;
                        end
                    end
                    S_REL: begin
                        if (!r_ack_s2) begin
                            r_tx_tmr <= '0;
                            if (r_tx_k == K_LAST) begin
                                r_dout     <= '0;
                                r_tx_ready <= 1'b1;
                                r_tx_st    <= S_IDLE;
                            end else begin
                                r_tx_k    <= r_tx_k + 1'b1;
                                r_tx_sh   <= w_tx_next;
                                r_dout    <= w_tx_next[DATA_W-1:0];
                                r_req_out <= 1'b1;
                                r_tx_st   <= S_REQ;
                            end
                        end else if (w_tmo) begin
                            r_tx_err   <= 1'b1;
                            r_dout     <= '0;
                            r_tx_ready <= 1'b1;
                            r_tx_st    <= S_IDLE;
                        end else begin
                            r_tx_tmr <= r_tx_tmr + 1'b1;
                        end
                    end
                    default: r_tx_st <= S_IDLE;
                endcase
            end
        end
    end

    rx_state_t             r_rx_st;
    logic [KW-1:0]         r_rx_k;
    logic [PAD_W-1:0]      r_rx_sh, w_rx_shift;
    logic                  r_ack_out, r_rx_valid;
    logic [MSG_BITS-1:0]   r_rx_data;

    // New chunks enter at the top, so after NCHUNK captures chunk 0 sits at bit 0.
    assign w_rx_shift = PAD_W'({r_din_s2, r_rx_sh} >> DATA_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_st    <= R_WAIT;
            r_rx_k     <= '0;
            r_rx_sh    <= '0;
            r_ack_out  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_abort || transmit) begin
                r_rx_st   <= R_WAIT;
                r_rx_k    <= '0;
                r_rx_sh   <= '0;
                r_ack_out <= 1'b0;
            end else begin
                case (r_rx_st)
                    R_WAIT: begin
                        if (r_req_s2) begin
                            r_rx_sh   <= w_rx_shift;
                            r_ack_out <= 1'b1;
                            r_rx_st   <= R_HOLD;
                        end
                    end
                    R_HOLD: begin
                        if (!r_req_s2) begin
                            r_ack_out <= 1'b0;
                            r_rx_st   <= R_WAIT;
                            if (r_rx_k == K_LAST) begin
                                r_rx_valid <= 1'b1;
                                r_rx_data  <= r_rx_sh[MSG_BITS-1:0];
                                r_rx_k     <= '0;
                            end else begin
                                r_rx_k <= r_rx_k + 1'b1;
                            end
                        end
                    end
                    default: r_rx_st <= R_WAIT;
                endcase
            end
        end
    end

    assign Request_out    = w_hold | (transmit & r_req_out);
    assign Ack_out        = w_hold | (~transmit & r_ack_out);
    assign inter_data_out = w_hold ? '1 : (transmit ? r_dout : '0);
    assign tx_ready       = r_tx_ready;
    assign tx_err         = r_tx_err;
    assign rx_valid       = r_rx_valid;
    assign rx_data        = r_rx_data;
    assign remote_rst     = r_remote_rst;
    assign o_dbg_tx_state = r_tx_st;
    assign o_dbg_rx_state = r_rx_st;

endmodule

// File: tb/tb_interboard_link.sv
// Two interboard_link instances cabled back to back; the bench can cut board A's
// inputs and drive them itself for timeout, glitch and transmit-flip scenarios.
module tb_interboard_link;
    localparam int DW  = 6;
    localparam int MB  = 22;
    localparam int RH  = 10;
    localparam int TO  = 16;
    localparam int NCH = (MB + DW - 1) / DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic a_tx, b_tx, a_vld, b_vld, a_lrr, b_lrr;
    logic [MB-1:0] a_dat, b_dat;
    logic a_rdy, a_err, a_req_o, a_ack_o, a_rxv, a_rr, a_dbg_rx;
    logic b_rdy, b_err, b_req_o, b_ack_o, b_rxv, b_rr, b_dbg_rx;
    logic [DW-1:0] a_do, b_do;
    logic [MB-1:0] a_rxd, b_rxd;
    logic [1:0] a_dbg_tx, b_dbg_tx;

    logic ovr, o_ack, o_req;
    logic [DW-1:0] o_din;
    logic a_req_i, a_ack_i;
    logic [DW-1:0] a_din;
    assign a_req_i = ovr ? o_req : b_req_o;
    assign a_ack_i = ovr ? o_ack : b_ack_o;
    assign a_din   = ovr ? o_din : b_do;

    interboard_link #(.DATA_W(DW), .MSG_BITS(MB), .RST_HOLD(RH), .TIMEOUT(TO)) u_a (
        .clk(clk), .rst(rst), .transmit(a_tx), .tx_valid(a_vld), .tx_data(a_dat),
        .tx_ready(a_rdy), .tx_err(a_err), .link_rst_req(a_lrr),
        .Request_in(a_req_i), .Ack_in(a_ack_i), .inter_data_in(a_din),
        .Request_out(a_req_o), .Ack_out(a_ack_o), .inter_data_out(a_do),
        .rx_valid(a_rxv), .rx_data(a_rxd), .remote_rst(a_rr),
        .o_dbg_tx_state(a_dbg_tx), .o_dbg_rx_state(a_dbg_rx));

    interboard_link #(.DATA_W(DW), .MSG_BITS(MB), .RST_HOLD(RH), .TIMEOUT(TO)) u_b (
        .clk(clk), .rst(rst), .transmit(b_tx), .tx_valid(b_vld), .tx_data(b_dat),
        .tx_ready(b_rdy), .tx_err(b_err), .link_rst_req(b_lrr),
        .Request_in(a_req_o), .Ack_in(a_ack_o), .inter_data_in(a_do),
        .Request_out(b_req_o), .Ack_out(b_ack_o), .inter_data_out(b_do),
        .rx_valid(b_rxv), .rx_data(b_rxd), .remote_rst(b_rr),
        .o_dbg_tx_state(b_dbg_tx), .o_dbg_rx_state(b_dbg_rx));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [MB-1:0] exp_ab[$];
    logic [MB-1:0] exp_ba[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int a_req_rises = 0, b_req_rises = 0, a_rr_cnt = 0, b_rr_cnt = 0, a_err_cnt = 0;
    int a_all1_cnt = 0, a_rxv_cnt = 0, b_rxv_cnt = 0, a_req_rise_cyc = 0, a_err_cyc = 0;
    logic a_req_q = 1'b0, b_req_q = 1'b0, a_err_req = 1'b0, a_err_rdy = 1'b0;

    // Monitor: event counters plus the receive-side scoreboard.
    always @(negedge clk) begin
        if (a_req_o && !a_req_q) begin
            a_req_rises++;
            a_req_rise_cyc = cyc;
        end
        if (b_req_o && !b_req_q) b_req_rises++;
        a_req_q = a_req_o;
        b_req_q = b_req_o;
        if (a_rr) a_rr_cnt++;
        if (b_rr) b_rr_cnt++;
        if (a_err) begin
            a_err_cnt++;
            a_err_cyc = cyc;
            a_err_req = a_req_o;
            a_err_rdy = a_rdy;
        end
        if (a_ack_o && a_req_o && (a_do == '1)) a_all1_cnt++;
        if (b_rxv) begin
            b_rxv_cnt++;
            if (exp_ab.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_b_unexpected: got %0h expected no message", b_rxd);
            end else begin
                check("rx_b_data", b_rxd, exp_ab.pop_front());
            end
        end
        if (a_rxv) begin
            a_rxv_cnt++;
            if (exp_ba.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_a_unexpected: got %0h expected no message", a_rxd);
            end else begin
                check("rx_a_data", a_rxd, exp_ba.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit from_b, input logic [MB-1:0] d, input bit push);
        int t = 0;
        while (((from_b ? b_rdy : a_rdy) !== 1'b1) && t < 100) begin
            tick();
            t++;
        end
        check(from_b ? "send_rdy_b" : "send_rdy_a", from_b ? b_rdy : a_rdy, 1);
        if (from_b) begin
            b_vld = 1'b1;
            b_dat = d;
        end else begin
            a_vld = 1'b1;
            a_dat = d;
        end
        if (push) begin
            if (from_b) exp_ba.push_back(d);
            else exp_ab.push_back(d);
        end
        tick();
        a_vld = 1'b0;
        b_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_ab.size() != 0 || exp_ba.size() != 0 || a_rdy !== 1'b1 || b_rdy !== 1'b1)
               && t < 500) begin
            tick();
            t++;
        end
        check("drain", exp_ab.size() + exp_ba.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MB-1:0] d;
        int r0, rx0, e0, s0, ra0, rb0;
        bit dir;
        rst = 1'b1;
        a_tx = 1'b1; b_tx = 1'b0;
        a_vld = 1'b0; b_vld = 1'b0; a_lrr = 1'b0; b_lrr = 1'b0;
        a_dat = '0; b_dat = '0;
        ovr = 1'b0; o_ack = 1'b0; o_req = 1'b0; o_din = '0;
        #2 rst = 1'b0;
        #1;
        check("reset_outs_a", {a_rdy, a_err, a_req_o, a_ack_o, a_do, a_rxv, a_rr, a_rxd}, 0);
        check("reset_outs_b", {b_rdy, b_err, b_req_o, b_ack_o, b_do, b_rxv, b_rr, b_rxd}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("rdy_after_reset_a", a_rdy, 1);
        check("rdy_after_reset_b", b_rdy, 1);

        // Directed loopback message.
        r0 = a_req_rises;
        rx0 = b_rxv_cnt;
        send(0, 22'h2A5F3C, 1);
        wait_drain();
        check("loop_req_pulses", a_req_rises - r0, NCH);
        check("loop_rx_count", b_rxv_cnt - rx0, 1);
        check("loop_rdy_back", a_rdy, 1);

        // Random traffic in both directions; a tx_valid mid-message must be ignored.
        for (int i = 0; i < 12; i++) begin
            dir = 1'($urandom_range(0, 1));
            a_tx = ~dir;
            b_tx = dir;
            tick(4);
            d = MB'($urandom);
            if (i == 0) d = '1;
            if (i == 1) d = '0;
            r0 = dir ? b_req_rises : a_req_rises;
            send(dir, d, 1);
            tick(3);
            check("busy_rdy", dir ? b_rdy : a_rdy, 0);
            if (dir) begin
                b_vld = 1'b1;
                b_dat = ~d;
            end else begin
                a_vld = 1'b1;
                a_dat = ~d;
            end
            tick();
            a_vld = 1'b0;
            b_vld = 1'b0;
            wait_drain();
            check("rand_req_pulses", (dir ? b_req_rises : a_req_rises) - r0, NCH);
        end
        a_tx = 1'b1;
        b_tx = 1'b0;
        tick(4);

        // Ack never arrives: timeout abort.
        b_tx = 1'b1;
        ovr = 1'b1;
        tick(4);
        e0 = a_err_cnt;
        send(0, MB'($urandom), 0);
        tick(TO + 10);
        check("tmo_err_count", a_err_cnt - e0, 1);
        check("tmo_latency", a_err_cyc - a_req_rise_cyc, TO);
        check("tmo_req_low", a_err_req, 0);
        check("tmo_rdy_high", a_err_rdy, 1);

        // transmit falls while the sender is in REL.
        send(0, MB'($urandom), 0);
        o_ack = 1'b1;
        begin
            int t = 0;
            while (a_req_o !== 1'b0 && t < 10) begin
                tick();
                t++;
            end
        end
        check("rel_entered", a_req_o, 0);
        tick();
        a_tx = 1'b0;
        e0 = a_err_cnt;
        tick(TO + 8);
        check("flip_no_err", a_err_cnt - e0, 0);
        check("flip_req_low", a_req_o, 0);
        check("flip_rdy", a_rdy, 1);
        o_ack = 1'b0;
        a_tx = 1'b1;
        tick(4);

        // All-ones glitch filtering on A's inputs.
        ra0 = a_rr_cnt;
        o_ack = 1'b1; o_req = 1'b1; o_din = '1;
        tick();
        o_ack = 1'b0; o_req = 1'b0; o_din = '0;
        tick(8);
        check("glitch_1cyc", a_rr_cnt - ra0, 0);
        o_ack = 1'b1; o_req = 1'b1; o_din = '1;
        tick(2);
        o_ack = 1'b0; o_req = 1'b0; o_din = '0;
        tick(8);
        check("pattern_2cyc", a_rr_cnt - ra0, 1);
        o_ack = 1'b1; o_req = 1'b1; o_din = '1;
        tick(6);
        o_ack = 1'b0; o_req = 1'b0; o_din = '0;
        tick(8);
        check("pattern_long", a_rr_cnt - ra0, 2);
        ovr = 1'b0;
        b_tx = 1'b0;
        tick(4);

        // Link reset from A.
        s0 = a_all1_cnt;
        ra0 = a_rr_cnt;
        rb0 = b_rr_cnt;
        a_lrr = 1'b1;
        tick();
        a_lrr = 1'b0;
        tick(2);
        check("rdy_in_hold", a_rdy, 0);
        tick(25);
        check("hold_cycles", a_all1_cnt - s0, RH);
        check("peer_remote_rst", b_rr_cnt - rb0, 1);
        check("self_remote_rst", a_rr_cnt - ra0, 0);
        send(0, MB'($urandom), 1);
        wait_drain();

        // Asynchronous reset in the middle of chunk 2.
        r0 = a_req_rises;
        send(0, MB'($urandom), 0);
        begin
            int t = 0;
            while ((a_req_rises - r0) < 3 && t < 200) begin
                tick();
                t++;
            end
        end
        check("chunk2_reached", a_req_rises - r0, 3);
        #2 rst = 1'b0;
        #1;
        check("async_rst_outs", {a_rdy, a_req_o, a_ack_o, a_do, a_err, b_rdy, b_req_o, b_ack_o,
                                 b_do, b_rxv, b_rr}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("rdy_after_async_rst", a_rdy, 1);
        rx0 = b_rxv_cnt;
        tick(20);
        check("partial_discarded", b_rxv_cnt - rx0, 0);
        send(0, 22'h15A0C3, 1);
        wait_drain();

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
